// File: rtl/uart_rx_pkg.sv
// Shared constants and types for the UART receive path: CSR addresses,
// default baud divider and the receiver FSM state encoding.
package uart_rx_pkg;

   typedef logic [11:0] CsrAddrT;

   localparam CsrAddrT UartRxDataAddr   = 12'h002;
   localparam CsrAddrT UartRxStatusAddr = 12'h003;

   // 12 MHz system clock at 115200 baud
   localparam int UartCyclesPerBit = 104;

   typedef enum logic [1:0] {Idle, Start, Data, Stop} UartRxStateT;

   // Layout of the status word as read through the CSR wrapper
   function automatic logic [2:0] uart_rx_status(input logic overrun,
                                                 input logic frame_err,
                                                 input logic valid);
      return {overrun, frame_err, valid};
   endfunction

endpackage

// File: rtl/uart_rx_sync_ff.sv
// N-stage synchronizer for asynchronous GPIO inputs with a configurable
// reset value so idle-high lines do not glitch low out of reset.
module sync_ff #(
   parameter int   Stages   = 2,
   parameter logic ResetVal = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [Stages-1:0] chain;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chain <= {Stages{ResetVal}};
      end else begin
         chain <= {chain[Stages-2:0], d};
      end
   end

   assign q = chain[Stages-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry byte buffer, sticky framing/overrun
// flags and a one-cycle interrupt pulse per received byte.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CyclesPerBit = UartCyclesPerBit,
   parameter int SyncStages   = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx,
   input  logic       rd_strobe,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       irq
);

   localparam int              CntW     = $clog2(CyclesPerBit);
   localparam logic [CntW-1:0] HalfLoad = CntW'(CyclesPerBit / 2 - 1);
   localparam logic [CntW-1:0] FullLoad = CntW'(CyclesPerBit - 1);
   localparam logic [CntW-1:0] CntOne   = CntW'(1);

   logic            rxs;
   logic            rx_prev;
   UartRxStateT     state;
   UartRxStateT     state_next;
   logic [CntW-1:0] bit_cnt;
   logic [CntW-1:0] bit_cnt_next;
   logic [2:0]      idx;
   logic [2:0]      idx_next;
   logic [7:0]      shreg;
   logic [7:0]      shreg_next;
   logic            store;
   logic            stop_bad;
   logic            cnt_zero;

   sync_ff #(
      .Stages   (SyncStages),
      .ResetVal (1'b1)
   ) u_rx_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (rx),
      .q       (rxs)
   );

   assign cnt_zero = (bit_cnt == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= Idle;
         bit_cnt <= '0;
         idx     <= '0;
         shreg   <= '0;
         rx_prev <= 1'b1;
      end else begin
         state   <= state_next;
         bit_cnt <= bit_cnt_next;
         idx     <= idx_next;
         shreg   <= shreg_next;
         rx_prev <= rxs;
      end
   end

   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      idx_next     = idx;
      shreg_next   = shreg;
      store        = 1'b0;
      stop_bad     = 1'b0;
      case (state)
         Idle: begin
            // Only a genuine 1->0 edge starts a frame, so a held-low break
            // cannot retrigger until the line returns high.
            if (rx_prev && !rxs) begin
               bit_cnt_next = HalfLoad;
               state_next   = Start;
            end
         end
         Start: begin
            if (cnt_zero) begin
               if (!rxs) begin
                  bit_cnt_next = FullLoad;
                  idx_next     = 3'd0;
                  state_next   = Data;
               end else begin
                  state_next = Idle;
               end
            end else begin
               bit_cnt_next = bit_cnt - CntOne;
            end
         end
         Data: begin
            if (cnt_zero) begin
               shreg_next   = {rxs, shreg[7:1]};
               bit_cnt_next = FullLoad;
               idx_next     = idx + 3'd1;
               if (idx == 3'd7) begin
                  state_next = Stop;
               end
            end else begin
               bit_cnt_next = bit_cnt - CntOne;
            end
         end
         Stop: begin
            if (cnt_zero) begin
               store      = 1'b1;
               stop_bad   = !rxs;
               state_next = Idle;
            end else begin
               bit_cnt_next = bit_cnt - CntOne;
            end
         end
         default: state_next = Idle;
      endcase
   end

   // A store in the same cycle as a read wins: the read only suppresses
   // the old flags, the new frame decides the fresh ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         irq       <= 1'b0;
      end else if (store) begin
         data      <= shreg;
         valid     <= 1'b1;
         irq       <= 1'b1;
         frame_err <= stop_bad | (frame_err & !rd_strobe);
         overrun   <= !rd_strobe & (overrun | valid);
      end else begin
         irq <= 1'b0;
         if (rd_strobe) begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 cycles per bit: a frame table plus
// hand sequences for latency, glitch, read/store collision and mid-frame reset.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rx;
   logic       rd_strobe;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;
   logic       irq;

   int checks_total  = 0;
   int checks_passed = 0;
   int cyc           = 0;
   int irq_count     = 0;
   int last_irq_cyc  = 0;

   typedef struct {
      logic       rd_before;
      logic [7:0] din;
      logic       stop;
      logic [7:0] exp_data;
      logic       exp_valid;
      logic       exp_ferr;
      logic       exp_ovr;
   } vec_t;

   vec_t vecs[6];

   uart_rx #(
      .CyclesPerBit (16),
      .SyncStages   (2)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rx        (rx),
      .rd_strobe (rd_strobe),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .overrun   (overrun),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (irq) begin
         irq_count    = irq_count + 1;
         last_irq_cyc = cyc;
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks_total++;
      if (act === exp) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One 8N1 frame at 16 cycles/bit; rd_strobe pulses during cycle rd_at
   // (relative to the start-bit edge), -1 for none.
   task automatic applyStimulus(input logic [7:0] b, input logic stop,
                                input int rd_at);
      int slot;
      for (int i = 0; i < 160; i++) begin
         slot = i / 16;
         if (slot == 0)      rx = 1'b0;
         else if (slot == 9) rx = stop;
         else                rx = b[slot-1];
         rd_strobe = (i == rd_at);
         waitCycles(1);
      end
      rx        = 1'b1;
      rd_strobe = 1'b0;
   endtask

   task automatic pulseRead();
      rd_strobe = 1'b1;
      waitCycles(1);
      rd_strobe = 1'b0;
   endtask

   initial begin
      int irq_before;
      int start_cyc;
      int lat;

      vecs[0] = '{1'b1, 8'h55, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 8'h12, 1'b1, 8'h12, 1'b1, 1'b1, 1'b1};
      vecs[2] = '{1'b1, 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 8'h11, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1};

      reset_n   = 1'b0;
      rx        = 1'b1;
      rd_strobe = 1'b0;
      waitCycles(3);
      checkOutput("reset_data", 32'(data), 32'h00);
      checkOutput("reset_valid", 32'(valid), 32'h0);
      checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
      checkOutput("reset_overrun", 32'(overrun), 32'h0);
      checkOutput("reset_irq", 32'(irq), 32'h0);
      reset_n = 1'b1;
      waitCycles(5);

      // First frame: latency from pin edge to irq, expected 154 +/- 1
      irq_before = irq_count;
      start_cyc  = cyc;
      applyStimulus(8'hA5, 1'b1, -1);
      lat = last_irq_cyc - start_cyc;
      checks_total++;
      if (lat >= 153 && lat <= 155 && irq_count > irq_before) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL irq_latency: got %0d cycles, expected 153..155", lat);
      end
      checkOutput("a5_irq_pulses", 32'(irq_count - irq_before), 32'd1);
      checkOutput("a5_data", 32'(data), 32'hA5);
      checkOutput("a5_valid", 32'(valid), 32'h1);
      checkOutput("a5_frame_err", 32'(frame_err), 32'h0);

      for (int v = 0; v < 6; v++) begin
         waitCycles(2);
         if (vecs[v].rd_before) pulseRead();
         irq_before = irq_count;
         applyStimulus(vecs[v].din, vecs[v].stop, -1);
         checkOutput($sformatf("vec%0d_data", v), 32'(data), 32'(vecs[v].exp_data));
         checkOutput($sformatf("vec%0d_valid", v), 32'(valid), 32'(vecs[v].exp_valid));
         checkOutput($sformatf("vec%0d_frame_err", v), 32'(frame_err), 32'(vecs[v].exp_ferr));
         checkOutput($sformatf("vec%0d_overrun", v), 32'(overrun), 32'(vecs[v].exp_ovr));
         checkOutput($sformatf("vec%0d_irq_pulses", v), 32'(irq_count - irq_before), 32'd1);
      end

      // Read strobe lands in the exact store cycle while valid/flags are set
      waitCycles(2);
      irq_before = irq_count;
      applyStimulus(8'h7E, 1'b1, 154);
      checkOutput("collide_data", 32'(data), 32'h7E);
      checkOutput("collide_valid", 32'(valid), 32'h1);
      checkOutput("collide_overrun", 32'(overrun), 32'h0);
      checkOutput("collide_frame_err", 32'(frame_err), 32'h0);
      checkOutput("collide_irq_pulses", 32'(irq_count - irq_before), 32'd1);

      pulseRead();
      waitCycles(1);
      checkOutput("read_valid", 32'(valid), 32'h0);
      checkOutput("read_frame_err", 32'(frame_err), 32'h0);
      checkOutput("read_overrun", 32'(overrun), 32'h0);

      irq_before = irq_count;
      rx = 1'b0;
      waitCycles(4);
      rx = 1'b1;
      waitCycles(40);
      checkOutput("glitch_valid", 32'(valid), 32'h0);
      checkOutput("glitch_irq_pulses", 32'(irq_count - irq_before), 32'd0);

      applyStimulus(8'h5A, 1'b1, -1);
      checkOutput("pre_reset_data", 32'(data), 32'h5A);
      waitCycles(2);

      // Reset during data bit 4 of 'hFF
      irq_before = irq_count;
      for (int i = 0; i < 160; i++) begin
         if (i == 90) begin
            checkOutput("midreset_data", 32'(data), 32'h00);
            checkOutput("midreset_valid", 32'(valid), 32'h0);
            checkOutput("midreset_frame_err", 32'(frame_err), 32'h0);
            checkOutput("midreset_overrun", 32'(overrun), 32'h0);
            checkOutput("midreset_irq", 32'(irq), 32'h0);
         end
         rx = (i < 16) ? 1'b0 : 1'b1;
         if (i == 88) reset_n = 1'b0;
         if (i == 92) reset_n = 1'b1;
         waitCycles(1);
      end
      rx = 1'b1;
      waitCycles(20);
      checkOutput("after_reset_valid", 32'(valid), 32'h0);
      checkOutput("after_reset_irq_pulses", 32'(irq_count - irq_before), 32'd0);

      irq_before = irq_count;
      applyStimulus(8'h81, 1'b1, -1);
      checkOutput("post_reset_data", 32'(data), 32'h81);
      checkOutput("post_reset_valid", 32'(valid), 32'h1);
      checkOutput("post_reset_irq_pulses", 32'(irq_count - irq_before), 32'd1);

      waitCycles(5);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the GPIO `RX` pin (index 2), the receive end of the UART link whose transmit side drives GPIO `TX`. It samples 8N1 frames, holds the received byte in a one-entry buffer and exposes it on a CSR (`UartRxDataAddr` = 'h002). It raises a one-cycle interrupt pulse toward the N-CLIC when a byte lands.

## Interface
- `CyclesPerBit`, default 104 (12 MHz / 115200): clock cycles per bit, ≥ 4.
- `SyncStages`, default 2: metastability flops on `rx`, ≥ 2.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset; one clock; no other clock domains.
- `rx`  in  1  raw asynchronous serial input; idle high.
- `rd_strobe`  in  1  CSR read of `UartRxDataAddr` this cycle; consumes the buffer.
- `data`  out  8  buffered byte; reset 'h00.
- `valid`  out  1  buffer holds an unread byte; reset 0.
- `frame_err`  out  1  sticky; last frame had stop bit = 0; reset 0.
- `overrun`  out  1  sticky; a byte arrived while `valid`=1; reset 0.
- `irq`  out  1  one-cycle pulse on each byte store; reset 0.

## Operation
- `rx` passes through `SyncStages` flops, reset to 1. All decisions use the synchronized value `rxs`.
- `bit_cnt` is a `$clog2(CyclesPerBit)`-bit down-counter. `idx` is a 3-bit data index.
- FSM states and transitions:
  - IDLE: when `rxs` falls (1→0), load `bit_cnt` = `CyclesPerBit/2 - 1` and go to START.
  - START: when `bit_cnt` reaches 0, sample `rxs`.
    - If 0: load `CyclesPerBit - 1`, clear `idx`, go to DATA.
    - If 1 (glitch): return to IDLE, store nothing.
  - DATA: at each `bit_cnt` = 0, shift `rxs` into the shift register MSB, so the byte assembles LSB-first. Reload the counter. After `idx` = 7, go to STOP.
  - STOP: at `bit_cnt` = 0, sample the stop bit and go to IDLE.
    - Stop bit = 1: the frame is good; `frame_err` keeps its value.
    - Stop bit = 0: set `frame_err`. The byte is still stored.
- Byte store (STOP exit):
  - `data` ← shift register, `valid` ← 1, `irq` ← 1 for one cycle.
  - If `valid` was already 1, the new byte overwrites `data` and `overrun` ← 1.
- `rd_strobe`:
  - Clears `valid`, `frame_err` and `overrun` on the following edge.
  - If a byte store happens in the same cycle, the store wins: `valid` = 1, `overrun` is not set, `frame_err` reflects the new frame.
  - `rd_strobe` while `valid` = 0 clears only the flags.
- A break (line held low) stores 'h00 with `frame_err` = 1. The FSM then stays in IDLE until `rxs` returns high and falls again.
- An IDLE falling-edge detect requires the previous `rxs` = 1. The previous-value flop resets to 1.

## Timing
- Input latency: `SyncStages` cycles from a pin edge to `rxs`.
- Start-bit check: `CyclesPerBit/2` cycles after the `rxs` fall.
- Sample spacing: each data and stop sample is `CyclesPerBit` cycles after the previous one, at bit centre.
- Frame-to-store: `valid`/`irq` assert `SyncStages + CyclesPerBit/2 + 9·CyclesPerBit` cycles (±1) after the pin's falling edge.
- Back-to-back frames: a new start bit can be detected the cycle after the STOP sample. That point is half a stop bit early, which tolerates ±4 % baud mismatch.
- Reset asserted mid-frame: all state and outputs return to reset values immediately, and the FSM goes to IDLE. Remaining bits of the partial frame are not detected as a start bit until a genuine 1→0 transition.
- All outputs are registered; no combinational path from `rx` or `rd_strobe` to any output.

## Structure
- Additions to `config_pkg`:
  - `UartRxDataAddr` ('h002) and `UartRxStatusAddr` ('h003) as `CsrAddrT`.
  - `UartCyclesPerBit`.
  - `typedef enum logic [1:0] {Idle, Start, Data, Stop} UartRxStateT`.
- One sub-module, `sync_ff`: a parameterised N-stage synchronizer with a reset value parameter, reusable for other GPIO inputs.
- The CSR wrapper is outside this block. Status reads as {`overrun`, `frame_err`, `valid`} in bits [2:0].

## Test plan
- `CyclesPerBit`=16: send 'hA5 with a good stop bit → `data`='hA5, `valid`=1, one `irq` pulse 2+8+144 cycles after the edge, `frame_err`=0.
- Glitch: `rx` low for 4 cycles → FSM returns to IDLE from START, `valid` stays 0, no `irq`.
- Send 'h3C then 'hC3 back-to-back without `rd_strobe` → `data`='hC3, `overrun`=1, two `irq` pulses. Then `rd_strobe` → `valid`=0, `overrun`=0.
- Send 'h55 with stop bit = 0 → `data`='h55, `frame_err`=1. Then send 'h12 good → `frame_err` still 1 until `rd_strobe`.
- `rd_strobe` in the same cycle as a store of 'h7E, with `valid` already 1 → `valid`=1, `data`='h7E, `overrun`=0.
- Assert `reset_n`=0 during data bit 4 of 'hFF, release, send 'h81 → only 'h81 stored, outputs all at reset values during reset.
